pc_stack: RTL and testbench
===========================

// Module: pc_stack
// PURPOSE
//  Parametrised program counter with an on-chip return-address stack.
//  Extends the basic 8-bit increment/load PC with:
//   - configurable width;
//   - explicit hold;
//   - optional PC-relative branch;
//   - CALL/RET via a LIFO of depth DEPTH.
//  Sits in the CPU datapath: feeds the instruction ROM address, driven by the control decoder.
// PARAMETERS
//  WIDTH  8  PC / address width in bits (>=2)
//  DEPTH  4  return-stack entries (>=1)
// PORTS
//  clk          in   1               clock, all state updates on posedge
//  reset        in   1               synchronous, active-high reset
//  op           in   3               operation select (see BEHAVIOUR)
//  data         in   WIDTH           jump target / signed offset
//  result       out  WIDTH           current PC, registered
//  sp_depth     out  $clog2(DEPTH+1) stack entries in use
//  stack_full   out  1               sp_depth == DEPTH
//  stack_empty  out  1               sp_depth == 0
//  stack_err    out  1               sticky over/underflow flag
// BEHAVIOUR
//  - Single clock; reset is synchronous and active-high. Reset has priority over every op.
//    - On reset: result=0, sp_depth=0, stack_err=0.
//    - Stack RAM contents are not cleared; they are don't-care.
//  - Reset mid-operation (e.g. during nested CALLs) discards all pushed entries.
//  - op is decoded each posedge. The new result is visible one cycle after op is sampled (latency 1).
//    - 000 HOLD: result unchanged.
//    - 001 INCR: result <= result+1, modulo 2^WIDTH (all-ones wraps to 0).
//    - 010 LOAD: result <= data.
//    - 011 REL: result <= result + sext(data), two's complement, modulo 2^WIDTH.
//      Gated by the macro below.
//    - 100 CALL: push (result+1 mod 2^WIDTH), sp_depth+1, result <= data.
//    - 101 RET: result <= top entry, sp_depth-1.
//    - 110, 111: reserved, behave as HOLD.
//  - Stack boundaries:
//    - CALL while stack_full: no push, no jump. result <= result+1, stack_err <= 1.
//    - RET while stack_empty: no pop. result <= result+1, stack_err <= 1.
//    - stack_err is cleared only by reset.
//    - Entries fill from index 0 up; top = entry[sp_depth-1].
//    - A RET immediately after a CALL returns the pushed address; no bypass hazard.
//  - stack_full / stack_empty:
//    - Decoded combinationally from the registered sp_depth.
//    - Both update in the same cycle as result.
//  - No other state. No combinational path from op/data to result.
// CONFIGURATION
//  PC_RELATIVE_EN
//   - Defined: op 011 performs the relative branch above; the adder is built.
//   - Undefined: op 011 behaves as HOLD and no offset adder is synthesised.
//   - All other ops are identical either way.
// TESTING (WIDTH=8, DEPTH=4 unless noted)
//  1. Reset:
//     - reset=1 for 2 cycles, then op=HOLD.
//     - Expect result=0x00, sp_depth=0, stack_empty=1, stack_full=0, stack_err=0.
//  2. Wrap:
//     - LOAD 0xFE, then INCR, INCR.
//     - Expect result 0xFE -> 0xFF -> 0x00; stack_err stays 0.
//  3. Call/return:
//     - At result=0x10, CALL data=0x40.
//       Expect result=0x40, sp_depth=1.
//     - Then RET.
//       Expect result=0x11, sp_depth=0, stack_empty=1.
//  4. Overflow:
//     - 4 nested CALLs (targets 0x20,0x21,0x22,0x23).
//       Expect stack_full=1.
//     - 5th CALL data=0x80 at 0x23.
//       Expect result=0x24, sp_depth=4, stack_err=1.
//     - 4 RETs.
//       Expect 0x23, 0x22, 0x21, then the pre-call PC+1.
//  5. Underflow + reset:
//     - RET at 0x05 with stack empty.
//       Expect result=0x06, stack_err=1.
//     - Assert reset during a CALL.
//       Expect result=0, sp_depth=0, stack_err=0.
//  6. Relative:
//     - At 0x10, REL data=0xFE.
//       With PC_RELATIVE_EN expect 0x0E.
//       Without it expect 0x10 (HOLD).

Source files
------------

// File: rtl/pc_stack.sv
// ---------------------------------------------------------------------------
// pc_stack
//   Parametrised program counter with an on-chip return-address stack.
//   Drives the instruction ROM address and is controlled by the decoder.
//
//   The PC can hold, increment, load, branch PC-relative, call and return.
//   CALL pushes the return address (PC+1) onto a LIFO of DEPTH entries.
//   RET pops that LIFO back into the PC.
//
//   Optional feature macro: PC_RELATIVE_EN
//     defined   : op 3'b011 adds the sign-extended data to the PC
//     undefined : op 3'b011 behaves as HOLD and no offset adder exists
//
// Parameters
//   WIDTH  PC / address width in bits (>= 2)
//   DEPTH  number of return-stack entries (>= 1)
//
// Ports
//   clk          in   clock, all state updates on posedge
//   reset        in   synchronous, active-high reset
//   op           in   operation select
//                     000 HOLD   001 INCR   010 LOAD   011 REL
//                     100 CALL   101 RET    110/111 HOLD
//   data         in   jump target / signed offset
//   result       out  current PC (registered)
//   sp_depth     out  number of stack entries in use
//   stack_full   out  sp_depth == DEPTH
//   stack_empty  out  sp_depth == 0
//   stack_err    out  sticky overflow/underflow flag, cleared by reset only
// ---------------------------------------------------------------------------
module pc_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 op,
    input  logic [WIDTH-1:0]           data,
    output logic [WIDTH-1:0]           result,
    output logic [$clog2(DEPTH+1)-1:0] sp_depth,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       stack_err
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_INCR = 3'b001,
        OP_LOAD = 3'b010,
        OP_REL  = 3'b011,
        OP_CALL = 3'b100,
        OP_RET  = 3'b101
    } op_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic             err_q, err_d;

    // Stack storage is intentionally not reset; entries above sp_q are dead.
    logic [WIDTH-1:0] stack_q [DEPTH];

    logic [WIDTH-1:0] pc_inc;
    logic             full, empty;
    logic             push_en;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    top_idx;

    assign pc_inc   = pc_q + WIDTH'(1);
    assign full     = (sp_q == SPW'(DEPTH));
    assign empty    = (sp_q == '0);
    assign push_idx = AW'(sp_q);
    assign top_idx  = AW'(sp_q - SPW'(1));

    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        err_d   = err_q;
        push_en = 1'b0;

        if (reset) begin
            pc_d  = '0;
            sp_d  = '0;
            err_d = 1'b0;
        end else begin
            case (op)
                OP_INCR: pc_d = pc_inc;
                OP_LOAD: pc_d = data;
`ifdef PC_RELATIVE_EN
                // Same-width addition is already two's-complement modulo
                // 2^WIDTH, so no explicit sign extension is needed.
                OP_REL:  pc_d = pc_q + data;
`endif
                OP_CALL: begin
                    if (full) begin
                        pc_d  = pc_inc;
                        err_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + SPW'(1);
                        pc_d    = data;
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        pc_d  = pc_inc;
                        err_d = 1'b1;
                    end else begin
                        sp_d = sp_q - SPW'(1);
                        pc_d = stack_q[top_idx];
                    end
                end
                default: pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        pc_q  <= pc_d;
        sp_q  <= sp_d;
        err_q <= err_d;
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign result      = pc_q;
    assign sp_depth    = sp_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_stack.sv
// ---------------------------------------------------------------------------
// tb_pc_stack
//   Scoreboard bench for pc_stack (WIDTH=8, DEPTH=4). The driver applies
//   directed then random ops on the falling edge and pushes the expected
//   post-edge state, computed by a queue-based return-stack model, into a
//   FIFO. The monitor pops and compares just after each rising edge.
// ---------------------------------------------------------------------------
module tb_pc_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SPW   = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       op = 3'b000;
    logic [WIDTH-1:0] data = '0;
    logic [WIDTH-1:0] result;
    logic [SPW-1:0]   sp_depth;
    logic             stack_full;
    logic             stack_empty;
    logic             stack_err;

    pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .data        (data),
        .result      (result),
        .sp_depth    (sp_depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] pc;
        logic [SPW-1:0]   depth;
        logic             full;
        logic             empty;
        logic             err;
    } exp_t;

    exp_t exp_q[$];

    // reference model state
    logic [WIDTH-1:0] m_pc;
    logic [WIDTH-1:0] m_stk[$];
    logic             m_err;

    int n_checks = 0;
    int n_pass   = 0;
    bit driver_done = 1'b0;

    task automatic step(input logic rst, input logic [2:0] o,
                        input logic [WIDTH-1:0] d, input string tag);
        exp_t e;
        logic [WIDTH-1:0] ret_addr;
        @(negedge clk);
        reset = rst;
        op    = o;
        data  = d;
        ret_addr = m_pc + 8'd1;
        if (rst) begin
            m_pc  = '0;
            m_stk.delete();
            m_err = 1'b0;
        end else begin
            case (o)
                3'b001: m_pc = ret_addr;
                3'b010: m_pc = d;
`ifdef PC_RELATIVE_EN
                3'b011: m_pc = m_pc + d;
`endif
                3'b100: begin
                    if (m_stk.size() == DEPTH) begin
                        m_pc  = ret_addr;
                        m_err = 1'b1;
                    end else begin
                        m_stk.push_back(ret_addr);
                        m_pc = d;
                    end
                end
                3'b101: begin
                    if (m_stk.size() == 0) begin
                        m_pc  = ret_addr;
                        m_err = 1'b1;
                    end else begin
                        m_pc = m_stk.pop_back();
                    end
                end
                default: ;
            endcase
        end
        e.tag   = tag;
        e.pc    = m_pc;
        e.depth = SPW'(m_stk.size());
        e.full  = (m_stk.size() == DEPTH);
        e.empty = (m_stk.size() == 0);
        e.err   = m_err;
        exp_q.push_back(e);
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (result === e.pc && sp_depth === e.depth &&
                    stack_full === e.full && stack_empty === e.empty &&
                    stack_err === e.err) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got pc=%h sp=%0d full=%b empty=%b err=%b, expected pc=%h sp=%0d full=%b empty=%b err=%b",
                             e.tag, result, sp_depth, stack_full, stack_empty, stack_err,
                             e.pc, e.depth, e.full, e.empty, e.err);
                end
            end
        end
    end

    // driver
    initial begin
        int r;
        logic [2:0] o;
        m_pc  = '0;
        m_err = 1'b0;

        // reset
        step(1'b1, 3'b000, 8'h00, "reset0");
        step(1'b1, 3'b000, 8'h00, "reset1");
        step(1'b0, 3'b000, 8'h00, "reset_hold");

        // wrap
        step(1'b0, 3'b010, 8'hFE, "wrap_load");
        step(1'b0, 3'b001, 8'h00, "wrap_incr_ff");
        step(1'b0, 3'b001, 8'h00, "wrap_incr_00");

        // call / return
        step(1'b0, 3'b010, 8'h10, "cr_load");
        step(1'b0, 3'b100, 8'h40, "cr_call");
        step(1'b0, 3'b101, 8'h00, "cr_ret");

        // overflow
        step(1'b0, 3'b010, 8'h1F, "ov_load");
        step(1'b0, 3'b100, 8'h20, "ov_call1");
        step(1'b0, 3'b100, 8'h21, "ov_call2");
        step(1'b0, 3'b100, 8'h22, "ov_call3");
        step(1'b0, 3'b100, 8'h23, "ov_call4_full");
        step(1'b0, 3'b100, 8'h80, "ov_call5_err");
        step(1'b0, 3'b101, 8'h00, "ov_ret1");
        step(1'b0, 3'b101, 8'h00, "ov_ret2");
        step(1'b0, 3'b101, 8'h00, "ov_ret3");
        step(1'b0, 3'b101, 8'h00, "ov_ret4");

        // underflow + reset during nested calls
        step(1'b1, 3'b000, 8'h00, "uf_reset");
        step(1'b0, 3'b010, 8'h05, "uf_load");
        step(1'b0, 3'b101, 8'h00, "uf_ret_empty");
        step(1'b0, 3'b100, 8'h30, "uf_call1");
        step(1'b0, 3'b100, 8'h31, "uf_call2");
        step(1'b1, 3'b100, 8'h32, "uf_reset_in_call");
        step(1'b0, 3'b111, 8'h55, "reserved_hold");

        // relative branch
        step(1'b0, 3'b010, 8'h10, "rel_load");
        step(1'b0, 3'b011, 8'hFE, "rel_back2");
        step(1'b0, 3'b011, 8'h05, "rel_fwd5");

        // random, biased toward CALL/RET so both stack boundaries get hit
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2)       o = 3'b000;
            else if (r < 30) o = 3'b100;
            else if (r < 58) o = 3'b101;
            else             o = 3'($urandom_range(0, 7));
            step(($urandom_range(0, 63) == 0), o, 8'($urandom), "random");
        end
        step(1'b0, 3'b000, 8'h00, "final_hold");
        driver_done = 1'b1;
    end

    // end of test: bounded drain of the scoreboard
    initial begin
        int budget;
        wait (driver_done);
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        repeat (2) @(posedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
